// File: rtl/vga_pkg.sv
// Shared definitions for the framebuffer VGA scanout: timing constants,
// framebuffer geometry, scan state encoding and small helper functions.
package vga_pkg;

    // 640x480@60 timing, in pixel clocks and lines
    localparam int unsigned H_VIS   = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;   // 800
    localparam int unsigned V_VIS   = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;   // 525

    // Framebuffer geometry
    localparam int unsigned FB_W     = 160;
    localparam int unsigned FB_H     = 120;
    localparam int unsigned FB_DEPTH = FB_W * FB_H;                   // 19200
    localparam int unsigned FB_AW    = 15;
    localparam int unsigned COLOUR_W = 3;
    localparam int unsigned CNT_W    = 10;

    typedef logic [FB_AW-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        VISIBLE = 2'd0,
        FRONT   = 2'd1,
        SYNC    = 2'd2,
        BACK    = 2'd3
    } scan_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // {R,G,B} one bit each -> full-scale 8-bit channels
    function automatic rgb888_t colour_to_rgb_f(input logic [COLOUR_W-1:0] c);
        rgb888_t rgb;
        rgb.r = {8{c[2]}};
        rgb.g = {8{c[1]}};
        rgb.b = {8{c[0]}};
        return rgb;
    endfunction

    // y*160 + x built from shifts (160 = 128 + 32)
    function automatic fb_addr_t fb_addr_f(input logic [7:0] x, input logic [7:0] y);
        return (fb_addr_t'(y) << 7) + (fb_addr_t'(y) << 5) + fb_addr_t'(x);
    endfunction

    // Region of a line/frame that a counter value falls in
    function automatic scan_state_e scan_state_f(input logic [CNT_W-1:0] cnt,
                                                 input int unsigned vis,
                                                 input int unsigned fp,
                                                 input int unsigned sync);
        if (32'(cnt) < vis)                  return VISIBLE;
        else if (32'(cnt) < vis + fp)        return FRONT;
        else if (32'(cnt) < vis + fp + sync) return SYNC;
        else                                 return BACK;
    endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// 19200x3 simple dual-port framebuffer: one write port, one registered
// read port. Read-first: a read and write to the same address in the same
// clk returns the previous contents.
// Ports:
//   clk        clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write colour
//   rd_en_i    read strobe (updates rd_data_o on the next edge)
//   rd_addr_i  read address
//   rd_data_o  registered read colour
module vga_fb_ram
    import vga_pkg::*;
(
    input  logic                clk,
    input  logic                wr_en_i,
    input  fb_addr_t            wr_addr_i,
    input  logic [COLOUR_W-1:0] wr_data_i,
    input  logic                rd_en_i,
    input  fb_addr_t            rd_addr_i,
    output logic [COLOUR_W-1:0] rd_data_o
);

    logic [COLOUR_W-1:0] mem_q [FB_DEPTH];
    logic [COLOUR_W-1:0] rd_data_q;

    // Contents are deliberately never reset so the array maps onto block RAM
    always_ff @(posedge clk) begin : ram_port
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vga_fb_scanout.sv
// Plot-interface responder that stores pixels into a 160x120x3 framebuffer
// and scans it out as 640x480@60 VGA with 4x4 pixel replication.
// Ports:
//   clk, rst                 50 MHz clock, synchronous active-high reset
//   plot_x/plot_y/plot_colour/plot   pixel write interface (no backpressure)
//   vga_r/g/b                8-bit colour, forced to 0 while blanked
//   vga_hs/vga_vs            active-low syncs
//   vga_blank_n              high inside the visible area
//   vga_clk_en               25 MHz pixel enable, high every 2nd clk
//   frame_start              one-clk pulse when the scan wraps to (0,0)
//   plot_count               saturating count of accepted plots
module vga_fb_scanout #(
    parameter int unsigned H_VIS  = vga_pkg::H_VIS,
    parameter int unsigned H_FP   = vga_pkg::H_FP,
    parameter int unsigned H_SYNC = vga_pkg::H_SYNC,
    parameter int unsigned H_BP   = vga_pkg::H_BP,
    parameter int unsigned V_VIS  = vga_pkg::V_VIS,
    parameter int unsigned V_FP   = vga_pkg::V_FP,
    parameter int unsigned V_SYNC = vga_pkg::V_SYNC,
    parameter int unsigned V_BP   = vga_pkg::V_BP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  plot_x,
    input  logic [6:0]  plot_y,
    input  logic [2:0]  plot_colour,
    input  logic        plot,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_clk_en,
    output logic        frame_start,
    output logic [15:0] plot_count
);

    import vga_pkg::*;

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    // Stage 0: pixel enable, counters, frame pulse
    logic             en_q, en_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             frame_start_q, frame_start_d;
    logic             h_last_c, v_last_c;

    // Scan FSM
    scan_state_e h_state_q, h_state_d;
    scan_state_e v_state_q, v_state_d;
    logic        hs_c, vs_c, blank_n_c;

    // Stage 1: read address and delayed timing
    fb_addr_t rd_addr_q, rd_addr_d;
    logic     hs1_q, vs1_q, blank1_q;

    // Stage 2: output registers
    rgb888_t  rgb_q;
    logic     hs2_q, vs2_q, blank2_q;

    // Write side
    logic                wr_en_c;
    fb_addr_t            wr_addr_c;
    logic                rd_en_c;
    logic [COLOUR_W-1:0] rd_data;
    logic [15:0]         plot_count_q, plot_count_d;

    // Counter advance, gated by the pixel enable
    always_comb begin : counter_next
        en_d          = ~en_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        h_last_c      = (hcnt_q == CNT_W'(H_TOT - 1));
        v_last_c      = (vcnt_q == CNT_W'(V_TOT - 1));
        frame_start_d = en_q & h_last_c & v_last_c;
        if (en_q) begin
            if (h_last_c) begin
                hcnt_d = '0;
                vcnt_d = v_last_c ? '0 : vcnt_q + CNT_W'(1);
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
        end
    end

    // Scan FSM state register
    always_ff @(posedge clk) begin : scan_state_reg
        if (rst) begin
            h_state_q <= VISIBLE;
            v_state_q <= VISIBLE;
        end else begin
            h_state_q <= h_state_d;
            v_state_q <= v_state_d;
        end
    end

    // State follows the next counter values so it always matches hcnt_q/vcnt_q
    always_comb begin : scan_state_next
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        if (en_q) begin
            h_state_d = scan_state_f(hcnt_d, H_VIS, H_FP, H_SYNC);
            v_state_d = scan_state_f(vcnt_d, V_VIS, V_FP, V_SYNC);
        end
    end

    // Timing decoded from the scan state
    always_comb begin : scan_state_out
        hs_c      = (h_state_q != SYNC);
        vs_c      = (v_state_q != SYNC);
        blank_n_c = (h_state_q == VISIBLE) && (v_state_q == VISIBLE);
    end

    // 4x4 replication: drop the two LSBs of each counter
    assign rd_addr_d = fb_addr_f(hcnt_q[CNT_W-1:2], vcnt_q[CNT_W-1:2]);

    // Counters and the two-stage read pipeline
    always_ff @(posedge clk) begin : pipe_reg
        if (rst) begin
            en_q          <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            frame_start_q <= 1'b0;
            rd_addr_q     <= '0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            blank1_q      <= 1'b0;
            rgb_q         <= '0;
            hs2_q         <= 1'b1;
            vs2_q         <= 1'b1;
            blank2_q      <= 1'b0;
        end else begin
            en_q          <= en_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_start_q <= frame_start_d;
            if (en_q) begin
                rd_addr_q <= rd_addr_d;
                hs1_q     <= hs_c;
                vs1_q     <= vs_c;
                blank1_q  <= blank_n_c;
                hs2_q     <= hs1_q;
                vs2_q     <= vs1_q;
                blank2_q  <= blank1_q;
                rgb_q     <= blank1_q ? colour_to_rgb_f(rd_data) : '0;
            end
        end
    end

    // The RAM samples the stage-1 address in the off-phase clk, so its data
    // is settled by the next pixel enable
    assign rd_en_c = ~en_q;

    assign wr_en_c   = plot & ~rst & (plot_x < 8'(FB_W)) & (plot_y < 7'(FB_H));
    assign wr_addr_c = fb_addr_f(plot_x, {1'b0, plot_y});

    vga_fb_ram u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en_c),
        .wr_addr_i (wr_addr_c),
        .wr_data_i (plot_colour),
        .rd_en_i   (rd_en_c),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (rd_data)
    );

    // Saturating accepted-plot counter
    always_comb begin : plot_count_next
        plot_count_d = plot_count_q;
        if (wr_en_c && (plot_count_q != 16'hFFFF)) begin
            plot_count_d = plot_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin : plot_count_reg
        if (rst) begin
            plot_count_q <= '0;
        end else begin
            plot_count_q <= plot_count_d;
        end
    end

    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign vga_hs      = hs2_q;
    assign vga_vs      = vs2_q;
    assign vga_blank_n = blank2_q;
    assign vga_clk_en  = en_q;
    assign frame_start = frame_start_q;
    assign plot_count  = plot_count_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: a full-timing instance and a shrunk-timing
// instance (so complete frames fit in a short run) are checked every clk
// against a reference computed from the elapsed clk count and a model
// framebuffer.
module tb_vga_fb_scanout;

    // Shrunk timing for the second instance (90 x 49 = 4410 enables/frame)
    localparam int unsigned S_HV = 64, S_HF = 8, S_HS = 12, S_HB = 6;
    localparam int unsigned S_VV = 40, S_VF = 3, S_VS = 2,  S_VB = 4;
    localparam int unsigned S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int unsigned S_VT = S_VV + S_VF + S_VS + S_VB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] plot_x = '0;
    logic [6:0] plot_y = '0;
    logic [2:0] plot_colour = '0;
    logic       plot = 1'b0;

    logic [7:0]  d_r, d_g, d_b, s_r, s_g, s_b;
    logic        d_hs, d_vs, d_bl, d_en, d_fs;
    logic        s_hs, s_vs, s_bl, s_en, s_fs;
    logic [15:0] d_cnt, s_cnt;

    always #10 clk = ~clk;

    vga_fb_scanout u_dut (
        .clk(clk), .rst(rst), .plot_x(plot_x), .plot_y(plot_y),
        .plot_colour(plot_colour), .plot(plot),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_hs(d_hs), .vga_vs(d_vs),
        .vga_blank_n(d_bl), .vga_clk_en(d_en), .frame_start(d_fs), .plot_count(d_cnt)
    );

    vga_fb_scanout #(
        .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_small (
        .clk(clk), .rst(rst), .plot_x(plot_x), .plot_y(plot_y),
        .plot_colour(plot_colour), .plot(plot),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs),
        .vga_blank_n(s_bl), .vga_clk_en(s_en), .frame_start(s_fs), .plot_count(s_cnt)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference state
    logic [2:0]  fb_m [19200];
    int unsigned cnt_m = 0;
    int unsigned k = 0;          // clk edges since the last reset edge
    logic [2:0]  rd_d = '0, rd_s = '0, col_d = '0, col_s = '0;
    logic        chk_rgb = 1'b1;
    logic        found;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, k);
        end
    endtask

    // Framebuffer address shown at scan position q of a frame of ht x vt
    function automatic int unsigned pos_addr(input int unsigned q, input int unsigned ht,
                                             input int unsigned vt);
        int unsigned pos, h, v;
        pos = q % (ht * vt);
        h   = pos % ht;
        v   = pos / ht;
        return (v / 4) * 160 + h / 4;
    endfunction

    function automatic logic [2:0] fb_rd(input int unsigned a);
        return (a < 19200) ? fb_m[a] : 3'b000;
    endfunction

    // Expected {rgb, hs, vs, blank_n, clk_en, frame_start, plot_count} after kk edges
    function automatic logic [63:0] exp_vec(input int unsigned kk,
            input int unsigned hv, input int unsigned hf, input int unsigned hsy, input int unsigned hb,
            input int unsigned vv, input int unsigned vf, input int unsigned vsy, input int unsigned vb,
            input logic [2:0] col, input int unsigned cnt);
        int unsigned ht, vt, p, pos, h, v;
        logic [7:0]  r, g, b;
        logic        hs_o, vs_o, bl, en, fs;
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vb;
        p  = kk / 2;
        r = '0; g = '0; b = '0; hs_o = 1'b1; vs_o = 1'b1; bl = 1'b0;
        if (p >= 2) begin
            pos  = (p - 2) % (ht * vt);
            h    = pos % ht;
            v    = pos / ht;
            bl   = (h < hv) && (v < vv);
            hs_o = !((h >= hv + hf) && (h < hv + hf + hsy));
            vs_o = !((v >= vv + vf) && (v < vv + vf + vsy));
            if (bl) begin
                r = {8{col[2]}};
                g = {8{col[1]}};
                b = {8{col[0]}};
            end
        end
        en = (kk % 2) == 1;
        fs = (kk > 0) && ((kk % 2) == 0) && ((p % (ht * vt)) == 0);
        return 64'({r, g, b, hs_o, vs_o, bl, en, fs, 16'(cnt)});
    endfunction

    // One clk: update the reference for this edge, then compare both instances
    task automatic step();
        logic [63:0] mask;
        @(posedge clk);
        if (rst) begin
            k     = 0;
            cnt_m = 0;
        end else begin
            k++;
            // Pixel fetched one clk after its address is taken; sees pre-write data
            if ((k % 2 == 1) && (k >= 3)) begin
                rd_d = fb_rd(pos_addr((k - 3) / 2, 800, 525));
                rd_s = fb_rd(pos_addr((k - 3) / 2, S_HT, S_VT));
            end
            if (k % 2 == 0) begin
                col_d = rd_d;
                col_s = rd_s;
            end
            if (plot && (plot_x < 8'd160) && (plot_y < 7'd120)) begin
                fb_m[int'(plot_y) * 160 + int'(plot_x)] = plot_colour;
                if (cnt_m < 65535) cnt_m++;
            end
        end
        #1;
        mask = chk_rgb ? 64'hFFFF_FFFF_FFFF_FFFF : ~(64'hFF_FFFF << 21);
        check_eq("dflt_outputs",
                 64'({d_r, d_g, d_b, d_hs, d_vs, d_bl, d_en, d_fs, d_cnt}) & mask,
                 exp_vec(k, 640, 16, 96, 48, 480, 10, 2, 33, col_d, cnt_m) & mask);
        check_eq("small_outputs",
                 64'({s_r, s_g, s_b, s_hs, s_vs, s_bl, s_en, s_fs, s_cnt}) & mask,
                 exp_vec(k, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, col_s, cnt_m) & mask);
    endtask

    task automatic do_plot(input int unsigned x, input int unsigned y, input logic [2:0] c);
        plot = 1'b1; plot_x = 8'(x); plot_y = 7'(y); plot_colour = c;
        step();
        plot = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;

        // Fillscreen pass; colour unknown until the whole buffer is written
        chk_rgb = 1'b0;
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                do_plot(x, y, 3'b001);
        for (int i = 0; i < 4; i++) step();
        chk_rgb = 1'b1;

        // Random plots, some out of range, with idle gaps
        for (int i = 0; i < 1500; i++) begin
            plot        = ($urandom_range(0, 3) != 0);
            plot_x      = 8'($urandom_range(0, 175));
            plot_y      = 7'($urandom_range(0, 127));
            plot_colour = 3'($urandom_range(0, 7));
            step();
        end
        plot = 1'b0;

        // Corner pixels and rejected coordinates
        do_plot(0, 0, 3'b100);
        do_plot(159, 119, 3'b010);
        do_plot(160, 5, 3'b111);
        do_plot(5, 120, 3'b111);
        do_plot(255, 127, 3'b111);

        // Write each pixel in the same clk as its last fetch of the frame
        for (int c = 0; c < 4; c++) begin
            found = 1'b0;
            for (int n = 0; n < 12000 && !found; n++) begin
                int unsigned q, pos, h, v;
                if (((k + 1) % 2 == 1) && (k + 1 >= 3)) begin
                    q   = (k - 2) / 2;
                    pos = q % (S_HT * S_VT);
                    h   = pos % S_HT;
                    v   = pos / S_HT;
                    if ((h < S_HV) && (v < S_VV) && (h % 4 == 3) && (v % 4 == 3)) begin
                        found = 1'b1;
                        do_plot(h / 4, v / 4, fb_m[(v / 4) * 160 + h / 4] ^ 3'b111);
                    end
                end
                if (!found) step();
            end
            check_eq("collide_found", 64'(found), 64'(1));
            for (int i = 0; i < 3; i++) step();
        end

        // Let the collided pixels show up again next frame
        for (int i = 0; i < 9000; i++) step();

        // Reset mid-line with a concurrent plot that must be dropped
        found = 1'b0;
        for (int n = 0; n < 4000 && !found; n++) begin
            if (((k / 2) % 800 == 300) && (k / 2 >= 800)) found = 1'b1;
            else step();
        end
        check_eq("rst_window", 64'(found), 64'(1));
        rst = 1'b1;
        plot = 1'b1; plot_x = 8'd1; plot_y = 7'd1; plot_colour = fb_m[161] ^ 3'b111;
        step();
        rst = 1'b0;
        plot = 1'b0;

        for (int i = 0; i < 12000; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Responder end of the plot interface (x, y, colour, plot) driven by the fillscreen and circle drawing engines.
- Captures plotted pixels into an internal 160x120x3 framebuffer.
- Independently scans the framebuffer out as 640x480@60 VGA: 4x4 pixel replication, 25 MHz pixel enable derived from the 50 MHz clock.
- Intended as an in-house replacement for the vendor adapter, and as a simulation sink for checking drawing engines.

Parameters:
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- H_VIS, 640, H_FP, 16, H_SYNC, 96, H_BP, 48: horizontal timing in pixel clocks (total 800)
- V_VIS, 480, V_FP, 10, V_SYNC, 2, V_BP, 33: vertical timing in lines (total 525)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- plot_x  in  8  pixel column
- plot_y  in  7  pixel row
- plot_colour  in  3  {R,G,B} one bit each
- plot  in  1  write strobe, one pixel per cycle when high
- vga_r  out  8  red
- vga_g  out  8  green
- vga_b  out  8  blue
- vga_hs  out  1  hsync, active-low
- vga_vs  out  1  vsync, active-low
- vga_blank_n  out  1  low outside the visible area
- vga_clk_en  out  1  pixel-enable strobe, high every 2nd clk
- frame_start  out  1  one-clk pulse when the scan reaches h=0, v=0
- plot_count  out  16  number of accepted (in-range) plots since reset; saturates at 16'hFFFF

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values:
  - pixel-enable toggle, hcnt, vcnt, plot_count = 0
  - vga_r/g/b = 0
  - vga_hs = 1, vga_vs = 1, vga_blank_n = 0
  - vga_clk_en = 0, frame_start = 0
  - Framebuffer contents are not cleared; clearing is the fillscreen engine's job.
- Write side:
  - When plot=1 with plot_x < FB_W and plot_y < FB_H, write plot_colour to address plot_y*160 + plot_x on that clk edge.
  - Compute the address with shifts: (y<<7) + (y<<5) + x, 15 bits, depth 19200.
  - Increment plot_count on each such write.
  - Out-of-range coordinates are ignored and not counted.
  - Writes are accepted every cycle with no backpressure, so no ready signal exists.
- Pixel enable:
  - A toggle flop drives vga_clk_en: high on alternate clks, starting one clk after reset release.
  - hcnt/vcnt advance only when vga_clk_en=1.
  - hcnt wraps 799 -> 0. vcnt increments on hcnt wrap and wraps 524 -> 0.
- Scan FSM (per line and per frame, derived from the counters): VISIBLE -> FRONT -> SYNC -> BACK.
  - hs low for hcnt in [656, 751].
  - vs low for vcnt in [490, 491].
  - blank_n high when hcnt < 640 and vcnt < 480.
- Read pipeline:
  - Stage 0: counters.
  - Stage 1: read address (vcnt>>2)*160 + (hcnt>>2) registered; hs/vs/blank delayed in step.
  - Stage 2: memory data registered onto vga_r/g/b; each bit expands to 8'hFF or 8'h00.
  - Total latency from counters to outputs is 2 pixel enables. hs, vs and blank_n carry identical delay so all VGA outputs stay aligned.
  - During blank, RGB is forced to 0.
- Read/write same address in the same clk: the read returns the old data (read-first). The new value appears on the next scan pass.
- frame_start is asserted for the single clk in which the counters transition to (0,0) under vga_clk_en.
- rst asserted mid-frame: counters and outputs return to reset values on the next edge. A write with plot=1 in the reset cycle is discarded.
- plot_count saturates: no wrap at 65535.

Decomposition:
- Package vga_pkg:
  - timing constants (H_*/V_*, totals 800/525)
  - FB_W/FB_H, the 15-bit fb_addr_t typedef
  - a colour3-to-RGB888 expansion function
  - the scan state enum (VISIBLE, FRONT, SYNC, BACK)
- One sub-module, vga_fb_ram: simple dual-port 19200x3, one write port, one registered read port, read-first, inferable as block RAM.

Test Plan:
- Reset then run 2*800*525 clks -> frame_start pulses exactly every 840000 clks. Per line: hs low 96 pixel enables (192 clks). Per frame: vs low 2 lines. blank_n high 640 enables per visible line.
- Plot (x=0,y=0,colour=3'b100), then scan -> at first visible pixel, after 2-enable latency, vga_r=8'hFF, vga_g=vga_b=0 for hcnt 0..3 on lines 0..3 only.
- Plot (159,119,3'b010) -> vga_g=8'hFF for hcnt 636..639, vcnt 476..479. Plot (160,5,3'b111) and (5,120,3'b111) -> no write and plot_count unchanged.
- Fill all 19200 pixels with 3'b001, then circle-style plots of 3'b010 -> plot_count=19200 plus circle count. Frame RGB matches the reference model pixel for pixel.
- Write to the address currently being read, same clk -> the current frame shows the old colour and the next frame shows the new one.
- Assert rst for 1 clk mid-line (hcnt=300, vcnt=200) -> next edge: hcnt=vcnt=0, outputs at reset values. The concurrent plot is discarded; framebuffer contents otherwise unchanged.
